// File: rtl/grf_hazard_ctrl_pkg.sv
// rtl/grf_hazard_ctrl_pkg.sv - shared forward-select encodings and pipeline Tuse/Tnew constants
package grf_hazard_ctrl_pkg;

    // Forward-select encodings driven onto fwd_rs_sel / fwd_rt_sel
    localparam logic [1:0] FWD_GRF   = 2'd0;
    localparam logic [1:0] FWD_E     = 2'd1;
    localparam logic [1:0] FWD_M     = 2'd2;

    // Tuse value meaning "operand never read"
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Per-opcode Tuse constants used by the decoder
    localparam logic [1:0] TUSE_BRANCH = 2'd0;  // beq/bne/jr compare in D
    localparam logic [1:0] TUSE_ALU    = 2'd1;  // ALU operands consumed in E
    localparam logic [1:0] TUSE_STORE  = 2'd2;  // sw data consumed in M

    // Per-opcode Tnew constants used by the decoder
    localparam logic [1:0] TNEW_LINK = 2'd0;    // jal/jalr link value known on entering E
    localparam logic [1:0] TNEW_ALU  = 2'd1;    // ALU result leaves E
    localparam logic [1:0] TNEW_LOAD = 2'd2;    // load data leaves M

endpackage

// File: rtl/grf_hazard_ctrl_if.sv
// rtl/grf_hazard_ctrl_if.sv - D-stage hazard request/response bundle
interface grf_hazard_ctrl_if #(
    parameter int AW = 5,
    parameter int TW = 2
);
    logic          d_valid;
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic [TW-1:0] d_tuse_rs;
    logic [TW-1:0] d_tuse_rt;
    logic          d_we;
    logic [AW-1:0] d_dst;
    logic [TW-1:0] d_tnew;
    logic          flush;
    logic          stall;
    logic [1:0]    fwd_rs_sel;
    logic [1:0]    fwd_rt_sel;

    // Pipeline side: presents the D-stage instruction, receives stall/forwarding
    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_dst, d_tnew, flush,
        input  stall, fwd_rs_sel, fwd_rt_sel
    );

    // Hazard controller side
    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_dst, d_tnew, flush,
        output stall, fwd_rs_sel, fwd_rt_sel
    );
endinterface

// File: rtl/hz_operand_chk.sv
// rtl/hz_operand_chk.sv - per-operand hazard detect and forward select against E/M entries
module hz_operand_chk
    import grf_hazard_ctrl_pkg::*;
#(
    parameter int AW = 5,
    parameter int TW = 2
) (
    input  logic          d_valid,
    input  logic [AW-1:0] addr,
    input  logic [TW-1:0] tuse,
    input  logic          e_valid,
    input  logic [AW-1:0] e_dst,
    input  logic [TW-1:0] e_tnew,
    input  logic          m_valid,
    input  logic [AW-1:0] m_dst,
    input  logic [TW-1:0] m_tnew,
    output logic          hazard,
    output logic [1:0]    fwd_sel
);

    logic e_match;
    logic m_match;

    // $0 never matches: writes to it are discarded by the GRF
    assign e_match = e_valid && (e_dst == addr) && (addr != '0);
    assign m_match = m_valid && (m_dst == addr) && (addr != '0);

    // Hazard when any matching producer is still further from ready than the consumer can wait
    assign hazard = (e_match && (e_tnew > tuse)) || (m_match && (m_tnew > tuse));

    // Nearest match wins; a non-ready nearest match hides an older ready one
    always_comb begin
        fwd_sel = FWD_GRF;
        if (d_valid) begin
            if (e_match) begin
                fwd_sel = (e_tnew == '0) ? FWD_E : FWD_GRF;
            end else if (m_match) begin
                fwd_sel = (m_tnew == '0) ? FWD_M : FWD_GRF;
            end
        end
    end

endmodule

// File: rtl/grf_hazard_ctrl.sv
// rtl/grf_hazard_ctrl.sv - E/M write tracking, D-stage stall and forward selects, stall counter
module grf_hazard_ctrl
    import grf_hazard_ctrl_pkg::*;
#(
    parameter int AW    = 5,
    parameter int TW    = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    grf_hazard_ctrl_if.slave hif,
    output logic             e_valid,
    output logic             m_valid,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             e_valid_q, e_valid_d;
    logic [AW-1:0]    e_dst_q,   e_dst_d;
    logic [TW-1:0]    e_tnew_q,  e_tnew_d;
    logic             m_valid_q, m_valid_d;
    logic [AW-1:0]    m_dst_q,   m_dst_d;
    logic [TW-1:0]    m_tnew_q,  m_tnew_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic hz_rs;
    logic hz_rt;
    logic stall_w;

    hz_operand_chk #(.AW(AW), .TW(TW)) u_chk_rs (
        .d_valid (hif.d_valid),
        .addr    (hif.d_rs),
        .tuse    (hif.d_tuse_rs),
        .e_valid (e_valid_q),
        .e_dst   (e_dst_q),
        .e_tnew  (e_tnew_q),
        .m_valid (m_valid_q),
        .m_dst   (m_dst_q),
        .m_tnew  (m_tnew_q),
        .hazard  (hz_rs),
        .fwd_sel (hif.fwd_rs_sel)
    );

    hz_operand_chk #(.AW(AW), .TW(TW)) u_chk_rt (
        .d_valid (hif.d_valid),
        .addr    (hif.d_rt),
        .tuse    (hif.d_tuse_rt),
        .e_valid (e_valid_q),
        .e_dst   (e_dst_q),
        .e_tnew  (e_tnew_q),
        .m_valid (m_valid_q),
        .m_dst   (m_dst_q),
        .m_tnew  (m_tnew_q),
        .hazard  (hz_rt),
        .fwd_sel (hif.fwd_rt_sel)
    );

    // Stall is purely combinational so it drops the moment reset clears the entries
    assign stall_w   = hif.d_valid && (hz_rs || hz_rt);
    assign hif.stall = stall_w;

    assign e_valid   = e_valid_q;
    assign m_valid   = m_valid_q;
    assign stall_cnt = stall_cnt_q;

    // Next-state: E takes D or a bubble, M always ages E, counter saturates
    always_comb begin
        e_valid_d = 1'b0;
        e_dst_d   = '0;
        e_tnew_d  = '0;
        if (!stall_w && !hif.flush) begin
            e_valid_d = hif.d_valid && hif.d_we && (hif.d_dst != '0);
            e_dst_d   = hif.d_dst;
            e_tnew_d  = hif.d_tnew;
        end

        m_valid_d = e_valid_q;
        m_dst_d   = e_dst_q;
        m_tnew_d  = (e_tnew_q == '0) ? '0 : (e_tnew_q - 1'b1);

        stall_cnt_d = stall_cnt_q;
        if (stall_w && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Tracking registers and counter, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid_q   <= 1'b0;
            e_dst_q     <= '0;
            e_tnew_q    <= '0;
            m_valid_q   <= 1'b0;
            m_dst_q     <= '0;
            m_tnew_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_valid_q   <= e_valid_d;
            e_dst_q     <= e_dst_d;
            e_tnew_q    <= e_tnew_d;
            m_valid_q   <= m_valid_d;
            m_dst_q     <= m_dst_d;
            m_tnew_q    <= m_tnew_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// tb/tb_grf_hazard_ctrl.sv - directed self-checking bench for grf_hazard_ctrl
module tb_grf_hazard_ctrl;
    import grf_hazard_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        e_valid;
    logic        m_valid;
    logic [31:0] stall_cnt;
    int          errors;
    int          checks;

    grf_hazard_ctrl_if #(.AW(5), .TW(2)) hif ();

    grf_hazard_ctrl #(.AW(5), .TW(2), .CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .hif       (hif),
        .e_valid   (e_valid),
        .m_valid   (m_valid),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                         input logic [4:0] rt, input logic [1:0] trt, input logic we,
                         input logic [4:0] dst, input logic [1:0] tnew, input logic fl);
        hif.d_valid = v;   hif.d_rs = rs;   hif.d_tuse_rs = trs;
        hif.d_rt = rt;     hif.d_tuse_rt = trt;
        hif.d_we = we;     hif.d_dst = dst; hif.d_tnew = tnew;
        hif.flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b0, 5'd0, 2'd0, 1'b0);
    endtask

    // Writer with no source operands
    task automatic issue_wr(input logic [4:0] dst, input logic [1:0] tnew);
        drive(1'b1, 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, dst, tnew, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL rst_e_valid: got %0d expected 0", e_valid); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %0d expected 0", m_valid); end
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0d expected 0", hif.stall); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", stall_cnt); end
        checks++; if (hif.fwd_rs_sel !== FWD_GRF) begin errors++; $display("FAIL rst_fwd_rs: got %0d expected 0", hif.fwd_rs_sel); end
        reset = 1'b0;
    endtask

    // lw $8 then addu reading $8 in E: one stall, then M entry still not ready (tnew=1)
    task automatic test_load_use();
        @(negedge clk); issue_wr(5'd8, TNEW_LOAD);
        #1;
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL lu_pre_stall: got %0d expected 0", hif.stall); end
        @(negedge clk); drive(1'b1, 5'd8, TUSE_ALU, 5'd0, TUSE_NONE, 1'b1, 5'd10, TNEW_ALU, 1'b0);
        #1;
        checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0d expected 1", hif.stall); end
        checks++; if (e_valid !== 1'b1) begin errors++; $display("FAIL lu_e_valid: got %0d expected 1", e_valid); end
        @(negedge clk); #1;
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %0d expected 0", hif.stall); end
        checks++; if (hif.fwd_rs_sel !== FWD_GRF) begin errors++; $display("FAIL lu_fwd_rs: got %0d expected 0", hif.fwd_rs_sel); end
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt); end
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %0d expected 0", e_valid); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL lu_m_valid: got %0d expected 1", m_valid); end
        @(negedge clk); idle();
        #1;
        checks++; if (e_valid !== 1'b1) begin errors++; $display("FAIL lu_addu_in_e: got %0d expected 1", e_valid); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lu_m_bubble: got %0d expected 0", m_valid); end
    endtask

    // addu $9 (tnew=1) then beq on $9 in D: one stall, then forward from M
    task automatic test_branch();
        @(negedge clk); issue_wr(5'd9, TNEW_ALU);
        @(negedge clk); drive(1'b1, 5'd9, TUSE_BRANCH, 5'd0, TUSE_NONE, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL br_stall: got %0d expected 1", hif.stall); end
        @(negedge clk); #1;
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL br_release: got %0d expected 0", hif.stall); end
        checks++; if (hif.fwd_rs_sel !== FWD_M) begin errors++; $display("FAIL br_fwd_rs: got %0d expected 2", hif.fwd_rs_sel); end
        checks++; if (hif.fwd_rt_sel !== FWD_GRF) begin errors++; $display("FAIL br_fwd_rt: got %0d expected 0", hif.fwd_rt_sel); end
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL br_cnt: got %0d expected 2", stall_cnt); end
        @(negedge clk); idle();
    endtask

    // E and M both ready for $5: E wins on both operands
    task automatic test_e_priority();
        @(negedge clk); issue_wr(5'd5, TNEW_ALU);
        @(negedge clk); issue_wr(5'd5, TNEW_LINK);
        @(negedge clk); drive(1'b1, 5'd5, TUSE_ALU, 5'd5, TUSE_BRANCH, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL ep_stall: got %0d expected 0", hif.stall); end
        checks++; if (hif.fwd_rs_sel !== FWD_E) begin errors++; $display("FAIL ep_fwd_rs: got %0d expected 1", hif.fwd_rs_sel); end
        checks++; if (hif.fwd_rt_sel !== FWD_E) begin errors++; $display("FAIL ep_fwd_rt: got %0d expected 1", hif.fwd_rt_sel); end
    endtask

    // Non-ready lw in E hides a ready addu in M; later M-only non-ready match stalls a branch
    task automatic test_stale_m();
        @(negedge clk); issue_wr(5'd5, TNEW_ALU);
        @(negedge clk); issue_wr(5'd5, TNEW_LOAD);
        @(negedge clk); drive(1'b1, 5'd0, TUSE_NONE, 5'd5, TUSE_STORE, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL sm_stall: got %0d expected 0", hif.stall); end
        checks++; if (hif.fwd_rt_sel !== FWD_GRF) begin errors++; $display("FAIL sm_fwd_rt: got %0d expected 0", hif.fwd_rt_sel); end
        checks++; if (hif.fwd_rs_sel !== FWD_GRF) begin errors++; $display("FAIL sm_fwd_rs: got %0d expected 0", hif.fwd_rs_sel); end
        @(negedge clk); #1;
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL sm_m1_store: got %0d expected 0", hif.stall); end
        checks++; if (hif.fwd_rt_sel !== FWD_GRF) begin errors++; $display("FAIL sm_m1_fwd: got %0d expected 0", hif.fwd_rt_sel); end
        hif.d_tuse_rt = TUSE_BRANCH;
        #1;
        checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL sm_m1_branch: got %0d expected 1", hif.stall); end
        idle();
        #1;
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL sm_bubble_nostall: got %0d expected 0", hif.stall); end
    endtask

    // Writes to $0 are never tracked; reads of $0 and bubbles never stall or forward
    task automatic test_zero_reg();
        @(negedge clk); issue_wr(5'd0, TNEW_LOAD);
        @(negedge clk); drive(1'b1, 5'd0, TUSE_BRANCH, 5'd0, TUSE_BRANCH, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL z_e_valid: got %0d expected 0", e_valid); end
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL z_stall: got %0d expected 0", hif.stall); end
        checks++; if (hif.fwd_rs_sel !== FWD_GRF) begin errors++; $display("FAIL z_fwd_rs: got %0d expected 0", hif.fwd_rs_sel); end
        checks++; if (hif.fwd_rt_sel !== FWD_GRF) begin errors++; $display("FAIL z_fwd_rt: got %0d expected 0", hif.fwd_rt_sel); end
        @(negedge clk); issue_wr(5'd8, TNEW_LOAD);
        @(negedge clk); drive(1'b0, 5'd8, TUSE_BRANCH, 5'd8, TUSE_BRANCH, 1'b0, 5'd0, 2'd0, 1'b0);
        #1;
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL z_bubble_stall: got %0d expected 0", hif.stall); end
        checks++; if (hif.fwd_rs_sel !== FWD_GRF) begin errors++; $display("FAIL z_bubble_fwd: got %0d expected 0", hif.fwd_rs_sel); end
    endtask

    // Flush kills the E entry; flush together with stall still counts the stall
    task automatic test_flush();
        @(negedge clk); drive(1'b1, 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd7, TNEW_LINK, 1'b1);
        @(negedge clk); idle();
        #1;
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL fl_e_valid: got %0d expected 0", e_valid); end
        @(negedge clk); issue_wr(5'd11, TNEW_LOAD);
        @(negedge clk); drive(1'b1, 5'd11, TUSE_ALU, 5'd0, TUSE_NONE, 1'b1, 5'd12, TNEW_ALU, 1'b1);
        #1;
        checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL fs_stall: got %0d expected 1", hif.stall); end
        @(negedge clk); #1;
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL fs_e_valid: got %0d expected 0", e_valid); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL fs_m_valid: got %0d expected 1", m_valid); end
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL fs_cnt: got %0d expected 3", stall_cnt); end
    endtask

    // Asynchronous reset while stalling clears everything before the next edge
    task automatic test_reset_mid();
        @(negedge clk); issue_wr(5'd12, TNEW_LOAD);
        @(negedge clk); drive(1'b1, 5'd12, TUSE_ALU, 5'd0, TUSE_NONE, 1'b1, 5'd13, TNEW_ALU, 1'b0);
        #1;
        checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL rm_pre_stall: got %0d expected 1", hif.stall); end
        #1 reset = 1'b1;
        #1;
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL rm_stall: got %0d expected 0", hif.stall); end
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL rm_e_valid: got %0d expected 0", e_valid); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rm_m_valid: got %0d expected 0", m_valid); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rm_cnt: got %0d expected 0", stall_cnt); end
        @(negedge clk); reset = 1'b0; idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_e_priority();
        test_stale_m();
        test_zero_reg();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
